// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction prefetch FIFO with redirect/flush for the 8-bit core.
// Optional discard statistics counter enabled by defining PREFETCH_STATS_EN.
module instruction_prefetch_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_address,
  input  logic                  consume,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] instruction_pc,
  output logic                  instruction_valid,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data
`ifdef PREFETCH_STATS_EN
  ,
  output logic [7:0]            discard_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQUEST = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_mem_request;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_beat;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_count_next;

  assign w_beat       = r_mem_request && mem_ready;
  assign w_push       = (r_state == REQUEST) && w_beat && !redirect;
  assign w_pop        = consume && (r_count != '0) && !redirect;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign instruction       = r_data[r_head];
  assign instruction_pc    = r_pc[r_head];
  assign instruction_valid = (r_count != '0);
  assign mem_request       = r_mem_request;
  assign mem_address       = r_mem_address;

  // A new request is only issued when its beat is guaranteed a free slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_fetch_pc    <= '0;
      r_mem_request <= 1'b0;
      r_mem_address <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fetch_pc <= redirect_address;
          end else if (w_count_next < DEPTH_C) begin
            r_mem_request <= 1'b1;
            r_mem_address <= r_fetch_pc;
            r_state       <= REQUEST;
          end
        end
        REQUEST: begin
          if (redirect) begin
            r_fetch_pc <= redirect_address;
            if (w_beat) r_mem_address <= redirect_address;
            else        r_state       <= DISCARD;
          end else if (w_beat) begin
            r_fetch_pc <= r_mem_address + 1'b1;
            if (w_count_next < DEPTH_C) begin
              r_mem_address <= r_mem_address + 1'b1;
            end else begin
              r_mem_request <= 1'b0;
              r_state       <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect) r_fetch_pc <= redirect_address;
          if (w_beat) begin
            r_mem_address <= redirect ? redirect_address : r_fetch_pc;
            r_state       <= REQUEST;
          end
        end
        default: begin
          r_mem_request <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  // Any redirect flushes the queue; stale instructions must never reach the core.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_data[r_tail] <= mem_data;
        r_pc[r_tail]   <= r_mem_address;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= w_count_next;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic       w_drop;
  logic [7:0] r_discard_count;

  assign w_drop        = w_beat && ((r_state == DISCARD) || ((r_state == REQUEST) && redirect));
  assign discard_count = r_discard_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_discard_count <= '0;
    end else if (w_drop && (r_discard_count != 8'hFF)) begin
      r_discard_count <= r_discard_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/instruction_prefetch_buffer.md
Name: instruction_prefetch_buffer

Overview:
- Upstream fetch stage of the 8-bit core. Fetches sequential 8-bit instructions from instruction memory into a small FIFO and presents them to the core with a valid/consume handshake.
- Handles core-issued redirects (jumps) by flushing queued instructions and restarting fetch at the new address.
- Decouples the core from instruction memory latency: memory may stall any number of cycles.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_WIDTH, 8, instruction address width.
- DATA_WIDTH, 8, instruction width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- redirect  input  1  core requests a fetch restart; sampled each rising edge.
- redirect_address  input  ADDR_WIDTH  new fetch address, valid with redirect.
- consume  input  1  core takes the head instruction this cycle.
- instruction  output  DATA_WIDTH  head FIFO entry.
- instruction_pc  output  ADDR_WIDTH  address of the head entry.
- instruction_valid  output  1  FIFO non-empty.
- mem_request  output  1  fetch request to instruction memory.
- mem_address  output  ADDR_WIDTH  fetch address; stable while mem_request is high.
- mem_ready  input  1  memory accepts the request and returns data in the same cycle.
- mem_data  input  DATA_WIDTH  instruction data, valid when mem_request && mem_ready.

Behaviour:
- Reset (reset low, asynchronous): FIFO empty; fetch_pc=0; state=IDLE; mem_request=0, mem_address=0; instruction_valid=0, instruction=0, instruction_pc=0.
- Outputs instruction/instruction_pc come from the head register; instruction_valid=(count!=0). All outputs are registered or derived only from state, never from inputs.
- Beat: a cycle with mem_request=1 and mem_ready=1. At most one request is outstanding at a time.
- FSM states:
  - IDLE:
    - If redirect: fetch_pc<=redirect_address; stay IDLE.
    - Else if count<DEPTH, or (count==DEPTH and consume): mem_request<=1, mem_address<=fetch_pc; go REQUEST.
  - REQUEST: mem_request and mem_address are held until a beat.
    - On a beat without redirect: push {mem_data, mem_address}; fetch_pc<=mem_address+1, wrapping 2^ADDR_WIDTH-1 -> 0.
    - After the push: if there is space next cycle, issue the next request back-to-back (mem_request stays 1, mem_address=mem_address+1). Otherwise drop mem_request and go IDLE.
  - DISCARD: the request is held until its beat; the beat's data is dropped. Then issue a request at fetch_pc and go REQUEST.
- Redirect during REQUEST:
  - Flush the FIFO (count=0) and set fetch_pc<=redirect_address.
  - If the redirect cycle is not a beat: go DISCARD. mem_address is not changed mid-request.
  - If the redirect cycle is a beat: drop the data and issue a new request at redirect_address in REQUEST.
- Redirect during DISCARD: update fetch_pc only.
- Consume:
  - Pops the head if instruction_valid. Consume on an empty FIFO is ignored.
  - A push and a pop in the same cycle leave count unchanged.
  - A pop while full frees the slot for the push in that cycle; no overflow ever occurs.
- Simultaneous redirect and consume: redirect wins; the FIFO is flushed and consume has no further effect.
- Latency: with the FIFO empty and mem_ready tied high, the instruction at address A is valid 2 cycles after redirect to A is sampled. Sustained throughput is 1 instruction/cycle.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined:
  - Adds output discard_count (8 bits).
  - Increments on every beat whose data is dropped (DISCARD beat, or a beat coinciding with redirect).
  - Saturates at 255; cleared by reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset with mem_ready=1, consume=1 held, no redirect -> mem_address sequence 0,1,2,…; instruction_pc matches the address of each delivered instruction; one instruction/cycle after the first; the sequence wraps 255->0.
- consume=0, mem_ready=1 -> exactly 4 beats at addresses 0..3; then mem_request=0; instruction_valid=1 with head pc 0. One consume -> exactly one further beat at address 4.
- mem_ready low for 5 cycles during a request to address 7 -> mem_address stays 7 with mem_request=1 throughout; the data arrives in the FIFO on the ready cycle.
- Redirect to 0x40 while a request to 0x03 is stalled -> FIFO flushed (instruction_valid=0 next cycle); the 0x03 beat is dropped (discard_count=1 with PREFETCH_STATS_EN); the next request is to 0x40.
- Redirect to 0x10 and consume in the same cycle with 3 entries queued -> FIFO empty next cycle; first delivered instruction_pc=0x10.
- Assert reset mid-REQUEST -> all outputs return to reset values immediately, without waiting for a clock edge.
